// File: rtl/fir_accumulator.sv
// Sums NUM_TAPS complex partial products per output sample, then rounds half-up,
// drops SHIFT LSBs and saturates each rail onto a valid/ready output register.
module fir_accumulator #(
    parameter int unsigned NUM_TAPS = 8,
    parameter int unsigned PP_W     = 52,
    parameter int unsigned GUARD_W  = 4,
    parameter int unsigned OUT_W    = 24,
    parameter int unsigned SHIFT    = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic [PP_W-1:0]  pp_I,
    input  logic [PP_W-1:0]  pp_Q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_I,
    output logic [OUT_W-1:0] out_Q,
    output logic             out_sat,
    output logic             align_err
);

    localparam int unsigned ACC_W = PP_W + GUARD_W;
    localparam int unsigned CNT_W = $clog2(NUM_TAPS);

    typedef logic signed [ACC_W-1:0] acc_t;
    // One extra bit so the rounding constant can never overflow the sum.
    typedef logic signed [ACC_W:0]   ext_t;

    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);
    localparam ext_t RND     = ext_t'(longint'(1) <<< (SHIFT - 1));
    localparam ext_t SAT_MAX = ext_t'((longint'(1) <<< (OUT_W - 1)) - longint'(1));
    localparam ext_t SAT_MIN = ext_t'(-(longint'(1) <<< (OUT_W - 1)));

    // Returns {saturated, value}.
    function automatic logic [OUT_W:0] round_sat(input acc_t s);
        ext_t r;
        r = (ext_t'(s) + RND) >>> SHIFT;
        if (r > SAT_MAX) begin
            round_sat = {1'b1, SAT_MAX[OUT_W-1:0]};
        end else if (r < SAT_MIN) begin
            round_sat = {1'b1, SAT_MIN[OUT_W-1:0]};
        end else begin
            round_sat = {1'b0, r[OUT_W-1:0]};
        end
    endfunction

    logic [CNT_W-1:0] tap_cnt_q, tap_cnt_d;
    acc_t             acc_i_q, acc_i_d;
    acc_t             acc_q_q, acc_q_d;
    logic [OUT_W-1:0] out_i_q, out_i_d;
    logic [OUT_W-1:0] out_q_q, out_q_d;
    logic             out_sat_q, out_sat_d;
    logic             out_valid_q, out_valid_d;
    logic             align_err_q, align_err_d;

    logic             xfer, start, complete;
    acc_t             pp_i_ext, pp_q_ext, sum_i, sum_q;
    logic [OUT_W:0]   rs_i, rs_q;

    assign in_ready = !(out_valid_q && !out_ready && (tap_cnt_q == LAST_TAP));

    always_comb begin
        xfer     = in_valid && in_ready;
        start    = (tap_cnt_q == '0) || in_first;
        pp_i_ext = acc_t'($signed(pp_I));
        pp_q_ext = acc_t'($signed(pp_Q));
        sum_i    = start ? pp_i_ext : acc_i_q + pp_i_ext;
        sum_q    = start ? pp_q_ext : acc_q_q + pp_q_ext;
        // A restart via in_first never completes since NUM_TAPS >= 2.
        complete = xfer && !start && (tap_cnt_q == LAST_TAP);
        rs_i     = round_sat(sum_i);
        rs_q     = round_sat(sum_q);

        tap_cnt_d   = tap_cnt_q;
        acc_i_d     = acc_i_q;
        acc_q_d     = acc_q_q;
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q && !out_ready;
        align_err_d = align_err_q;

        if (xfer) begin
            acc_i_d   = sum_i;
            acc_q_d   = sum_q;
            tap_cnt_d = start ? CNT_W'(1) : tap_cnt_q + 1'b1;
            if (in_first && (tap_cnt_q != '0)) begin
                align_err_d = 1'b1;
            end
        end

        if (complete) begin
            tap_cnt_d   = '0;
            out_i_d     = rs_i[OUT_W-1:0];
            out_q_d     = rs_q[OUT_W-1:0];
            out_sat_d   = rs_i[OUT_W] || rs_q[OUT_W];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tap_cnt_q   <= '0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            tap_cnt_q   <= tap_cnt_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
            align_err_q <= align_err_d;
        end
    end

    assign out_I     = out_i_q;
    assign out_Q     = out_q_q;
    assign out_sat   = out_sat_q;
    assign out_valid = out_valid_q;
    assign align_err = align_err_q;

endmodule

// File: tb/tb_fir_accumulator.sv
// Self-checking bench for fir_accumulator with NUM_TAPS = 4; expected results come from
// plain 64-bit arithmetic on the tap values sent.
module tb_fir_accumulator;

    localparam int NT    = 4;
    localparam int PP_W  = 52;
    localparam int OUT_W = 24;
    localparam longint MAXV = (longint'(1) <<< (OUT_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (OUT_W - 1));

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_first = 1'b0;
    logic             out_ready = 1'b1;
    logic [PP_W-1:0]  pp_I = '0;
    logic [PP_W-1:0]  pp_Q = '0;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_I;
    logic [OUT_W-1:0] out_Q;
    logic             out_sat;
    logic             align_err;

    int n_checks = 0;
    int n_fail   = 0;

    fir_accumulator #(
        .NUM_TAPS(NT),
        .PP_W    (PP_W),
        .GUARD_W (4),
        .OUT_W   (OUT_W),
        .SHIFT   (24)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_first (in_first),
        .pp_I     (pp_I),
        .pp_Q     (pp_Q),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_I    (out_I),
        .out_Q    (out_Q),
        .out_sat  (out_sat),
        .align_err(align_err)
    );

    always #5 clk = ~clk;

    function automatic longint model_round(input longint s);
        return (s + (longint'(1) <<< 23)) >>> 24;
    endfunction

    function automatic longint model_out(input longint s);
        longint r;
        r = model_round(s);
        if (r > MAXV) return MAXV;
        if (r < MINV) return MINV;
        return r;
    endfunction

    function automatic bit model_sat(input longint si, input longint sq);
        longint ri, rq;
        ri = model_round(si);
        rq = model_round(sq);
        return (ri > MAXV) || (ri < MINV) || (rq > MAXV) || (rq < MINV);
    endfunction

    function automatic longint rand_pp();
        longint v;
        v = {$urandom, $urandom};
        return v >>> $urandom_range(12, 34);
    endfunction

    function automatic longint sout_i();
        return longint'($signed(out_I));
    endfunction

    function automatic longint sout_q();
        return longint'($signed(out_Q));
    endfunction

    // Presents one tap and returns #1 after the posedge on which it transferred.
    task automatic send_tap(input longint vi, input longint vq, input bit first);
        int w;
        w = 0;
        pp_I = vi[PP_W-1:0];
        pp_Q = vq[PP_W-1:0];
        in_first = first;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL send_tap_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, w);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, out_I, out_Q, out_sat, align_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%0b I=%0d Q=%0d sat=%0b err=%0b, required all 0",
                     out_valid, out_I, out_Q, out_sat, align_err);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
        end
    endtask

    task automatic test_sum(input string name, input longint vi, input longint vq);
        out_ready = 1'b1;
        for (int t = 0; t < NT; t++) send_tap(vi, vq, t == 0);
        n_checks++;
        if (out_valid !== 1'b1 || sout_i() !== model_out(vi * NT) || sout_q() !== model_out(vq * NT)
            || out_sat !== model_sat(vi * NT, vq * NT)) begin
            n_fail++;
            $display("FAIL %s: valid=%0b I=%0d Q=%0d sat=%0b, required 1 %0d %0d %0b", name,
                     out_valid, sout_i(), sout_q(), out_sat, model_out(vi * NT),
                     model_out(vq * NT), model_sat(vi * NT, vq * NT));
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pulse: out_valid=%0b one cycle later, required 0", name, out_valid);
        end
    endtask

    task automatic test_rounding();
        longint vals[4];
        vals[0] = longint'(1) <<< 23;
        vals[1] = (longint'(1) <<< 23) - 1;
        vals[2] = -(longint'(1) <<< 23);
        vals[3] = -(longint'(1) <<< 23) - 1;
        for (int k = 0; k < 4; k++) begin
            send_tap(vals[k], 0, 1'b1);
            for (int t = 1; t < NT; t++) send_tap(0, 0, 1'b0);
            n_checks++;
            if (out_valid !== 1'b1 || sout_i() !== model_out(vals[k]) || out_sat !== 1'b0) begin
                n_fail++;
                $display("FAIL rounding_%0d: valid=%0b I=%0d sat=%0b, required 1 %0d 0", k,
                         out_valid, sout_i(), out_sat, model_out(vals[k]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int s = 0; s < 10; s++) begin
            longint si, sq, vi, vq;
            si = 0;
            sq = 0;
            for (int t = 0; t < NT; t++) begin
                vi = rand_pp();
                vq = rand_pp();
                si += vi;
                sq += vq;
                send_tap(vi, vq, (t == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
            end
            n_checks++;
            if (out_valid !== 1'b1 || sout_i() !== model_out(si) || sout_q() !== model_out(sq)
                || out_sat !== model_sat(si, sq)) begin
                n_fail++;
                $display("FAIL random_%0d: valid=%0b I=%0d Q=%0d sat=%0b, required 1 %0d %0d %0b",
                         s, out_valid, sout_i(), sout_q(), out_sat, model_out(si),
                         model_out(sq), model_sat(si, sq));
            end
            if (s % 3 == 2) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        longint s1i, s1q, s2i, s2q, vi, vq;
        s1i = 0; s1q = 0; s2i = 0; s2q = 0;
        out_ready = 1'b0;
        for (int t = 0; t < 2 * NT - 1; t++) begin
            vi = rand_pp();
            vq = rand_pp();
            if (t < NT) begin
                s1i += vi;
                s1q += vq;
            end else begin
                s2i += vi;
                s2q += vq;
            end
            send_tap(vi, vq, t == 0 || t == NT);
            if (t >= NT - 1) begin
                n_checks++;
                if (out_valid !== 1'b1 || sout_i() !== model_out(s1i)
                    || sout_q() !== model_out(s1q) || out_sat !== model_sat(s1i, s1q)) begin
                    n_fail++;
                    $display("FAIL bp_hold_%0d: valid=%0b I=%0d Q=%0d, required 1 %0d %0d", t,
                             out_valid, sout_i(), sout_q(), model_out(s1i), model_out(s1q));
                end
            end
        end
        vi = rand_pp();
        vq = rand_pp();
        s2i += vi;
        s2q += vq;
        pp_I = vi[PP_W-1:0];
        pp_Q = vq[PP_W-1:0];
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || sout_i() !== model_out(s1i)) begin
                n_fail++;
                $display("FAIL bp_stall: in_ready=%0b I=%0d, required 0 %0d", in_ready, sout_i(),
                         model_out(s1i));
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%0b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || sout_i() !== model_out(s2i) || sout_q() !== model_out(s2q)
            || out_sat !== model_sat(s2i, s2q)) begin
            n_fail++;
            $display("FAIL bp_second: valid=%0b I=%0d Q=%0d sat=%0b, required 1 %0d %0d %0b",
                     out_valid, sout_i(), sout_q(), out_sat, model_out(s2i), model_out(s2q),
                     model_sat(s2i, s2q));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: out_valid=%0b, required 0", out_valid);
        end
    endtask

    task automatic test_misalign();
        longint si, sq, vi, vq;
        out_ready = 1'b1;
        send_tap(rand_pp(), rand_pp(), 1'b1);
        send_tap(rand_pp(), rand_pp(), 1'b0);
        n_checks++;
        if (align_err !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_pre: align_err=%0b, required 0", align_err);
        end
        si = 0;
        sq = 0;
        for (int t = 0; t < NT; t++) begin
            vi = rand_pp();
            vq = rand_pp();
            si += vi;
            sq += vq;
            send_tap(vi, vq, t == 0);
            if (t == 0) begin
                n_checks++;
                if (align_err !== 1'b1 || out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL misalign_flag: align_err=%0b valid=%0b, required 1 0",
                             align_err, out_valid);
                end
            end
        end
        n_checks++;
        if (out_valid !== 1'b1 || sout_i() !== model_out(si) || sout_q() !== model_out(sq)
            || align_err !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_sum: valid=%0b I=%0d Q=%0d err=%0b, required 1 %0d %0d 1",
                     out_valid, sout_i(), sout_q(), align_err, model_out(si), model_out(sq));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        longint v;
        v = longint'(1) <<< 44;
        out_ready = 1'b0;
        for (int t = 0; t < NT + 2; t++) send_tap(rand_pp(), rand_pp(), t == 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, out_I, out_Q, out_sat, align_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: valid=%0b I=%0d Q=%0d sat=%0b err=%0b, required 0",
                     out_valid, out_I, out_Q, out_sat, align_err);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < NT; t++) send_tap(v, 0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || sout_i() !== 4194304 || sout_q() !== 0 || align_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_sum: valid=%0b I=%0d Q=%0d err=%0b, required 1 4194304 0 0",
                     out_valid, sout_i(), sout_q(), align_err);
        end
    endtask

    initial begin
        test_reset();
        test_sum("basic_sum", longint'(1) <<< 44, -(longint'(1) <<< 44));
        n_checks++;
        if (model_out(longint'(4) <<< 44) !== 4194304 || model_sat(longint'(4) <<< 45, 0) !== 1'b1) begin
            n_fail++;
            $display("FAIL model_sanity: reference model disagrees with known results");
        end
        test_sum("saturation", longint'(1) <<< 45, -(longint'(1) <<< 45));
        test_rounding();
        test_back_to_back();
        test_backpressure();
        test_misalign();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
